prog_loader: RTL and testbench

- Upstream boot stage of the 4-bit CPU: receives a program as a stream of 4-bit nibbles over a valid/ready handshake.
- Assembles each group of four nibbles into a 16-bit instruction and writes it into the writable instruction memory at addresses 0..WORDS-1.
- Holds the CPU's program counter at 0 via set_pc while loading, then releases the CPU to run.

---
 rtl/prog_loader_if.sv | 28 ++
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Boot-loader bus: nibble stream in, instruction-memory write port and CPU control out.
// master = loader side, slave = source/memory/CPU side.
interface prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int NIB_W  = 4
);
    logic                 load_start;
    logic                 nib_valid;
    logic [NIB_W-1:0]     NIB;
    logic                 nib_ready;
    logic                 im_we;
    logic [ADDR_W-1:0]    IM_WADDR;
    logic [4*NIB_W-1:0]   IM_WDATA;
    logic                 set_pc;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        input  load_start, nib_valid, NIB,
        output nib_ready, im_we, IM_WADDR, IM_WDATA, set_pc, busy, done, err
    );

    modport slave (
        output load_start, nib_valid, NIB,
        input  nib_ready, im_we, IM_WADDR, IM_WDATA, set_pc, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: packs nibbles MSB-first into 16-bit words, writes them to instruction memory, then releases the CPU.
// Optional checksum nibble after the last word is enabled with PROG_LOADER_CSUM_EN.
//
// state | meaning
// IDLE  | after reset, CPU held at PC 0, waiting for load_start
// LOAD  | accepting nibbles of the current word
// WRITE | one-cycle instruction memory write pulse
// CHECK | waiting for the checksum nibble (PROG_LOADER_CSUM_EN only)
// ERROR | checksum mismatch, CPU held (PROG_LOADER_CSUM_EN only)
// RUN   | program loaded, CPU running
module prog_loader #(
    parameter int WORDS  = 16,
    parameter int ADDR_W = 4,
    parameter int NIB_W  = 4
) (
    input logic           clk,
    input logic           reset,
    prog_loader_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

`ifdef PROG_LOADER_CSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, CHECK, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;
`endif

    state_t               state;
    logic [1:0]           cnt;
    logic                 ready;
    logic                 wr_en;
    logic [ADDR_W-1:0]    waddr;
    logic [4*NIB_W-1:0]   wdata;
    logic                 pc_hold;
    logic                 in_load;
    logic                 loaded;
    logic                 start_ok;
`ifdef PROG_LOADER_CSUM_EN
    logic [NIB_W-1:0]     csum;
    logic                 err_flag;
`endif

    // load_start is honoured only when no session is in flight
    always_comb begin
        start_ok = bus.load_start && (state == IDLE || state == RUN
`ifdef PROG_LOADER_CSUM_EN
                                      || state == ERROR
`endif
                                     );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ready    <= 1'b0;
            wr_en    <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            pc_hold  <= 1'b1;
            in_load  <= 1'b0;
            loaded   <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            csum     <= '0;
            err_flag <= 1'b0;
`endif
        end else if (start_ok) begin
            state    <= LOAD;
            cnt      <= '0;
            ready    <= 1'b1;
            waddr    <= '0;
            pc_hold  <= 1'b1;
            in_load  <= 1'b1;
            loaded   <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            csum     <= '0;
            err_flag <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (bus.nib_valid && ready) begin
                        wdata <= {wdata[3*NIB_W-1:0], bus.NIB};
                        cnt   <= cnt + 2'd1;
`ifdef PROG_LOADER_CSUM_EN
                        csum  <= csum ^ bus.NIB;
`endif
                        if (cnt == 2'd3) begin
                            state <= WRITE;
                            ready <= 1'b0;
                            wr_en <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    if (waddr == LAST) begin
`ifdef PROG_LOADER_CSUM_EN
                        state   <= CHECK;
                        ready   <= 1'b1;
`else
                        state   <= RUN;
                        pc_hold <= 1'b0;
                        loaded  <= 1'b1;
                        in_load <= 1'b0;
`endif
                    end else begin
                        state <= LOAD;
                        waddr <= waddr + 1'b1;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end
                end
`ifdef PROG_LOADER_CSUM_EN
                CHECK: begin
                    if (bus.nib_valid && ready) begin
                        ready   <= 1'b0;
                        in_load <= 1'b0;
                        if (bus.NIB == csum) begin
                            state   <= RUN;
                            pc_hold <= 1'b0;
                            loaded  <= 1'b1;
                        end else begin
                            state    <= ERROR;
                            err_flag <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.nib_ready = ready;
    assign bus.im_we     = wr_en;
    assign bus.IM_WADDR  = waddr;
    assign bus.IM_WDATA  = wdata;
    assign bus.set_pc    = pc_hold;
    assign bus.busy      = in_load;
    assign bus.done      = loaded;
`ifdef PROG_LOADER_CSUM_EN
    assign bus.err       = err_flag;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized nibble streams against a word-level expected-write model.
module tb_prog_loader;
    localparam int WORDS = 2;
    localparam logic [25:0] RST_VEC = {1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(4), .NIB_W(4)) bus ();

    prog_loader #(.WORDS(WORDS), .ADDR_W(4), .NIB_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          cyc;
        logic        rdy;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  stream[$];
    wr_t         got[$];
    int          accepted;

    function automatic logic [15:0] exp_word(input int w);
        return {stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]};
    endfunction

    // Expected checksum is the XOR of every data nibble of the session.
    task automatic add_csum(input bit bad);
        logic [3:0] x = 4'h0;
        for (int i = 0; i < 4*WORDS; i++) x ^= stream[i];
        if (bad) x ^= 4'($urandom_range(1, 15));
        stream.push_back(x);
    endtask

    task automatic fill_random();
        stream.delete();
        for (int i = 0; i < 4*WORDS; i++) stream.push_back(4'($urandom));
`ifdef PROG_LOADER_CSUM_EN
        add_csum(1'b0);
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
    endtask

    // Drives the stream with the chosen valid pattern and logs every write pulse.
    // mode 0: valid always high, 1: valid every other cycle, 2: random valid + stray load_start.
    task automatic run_session(input int mode, input int stop_after, output bit timed_out);
        int  idx = 0;
        int  total = stream.size();
        bit  v;
        wr_t r;
        got.delete();
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (bus.im_we) begin
                r.addr = bus.IM_WADDR;
                r.data = bus.IM_WDATA;
                r.cyc  = cyc;
                r.rdy  = bus.nib_ready;
                got.push_back(r);
            end
            if (idx == stop_after || (idx == total && got.size() >= WORDS)) begin
                timed_out = 1'b0;
                break;
            end
            bus.load_start = (mode == 2 && got.size() < WORDS) ? ($urandom_range(0, 5) == 0) : 1'b0;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            if (idx < total) begin
                bus.nib_valid = v;
                bus.NIB       = v ? stream[idx] : 4'($urandom);
            end else begin
                bus.nib_valid = 1'($urandom_range(0, 1));
                bus.NIB       = 4'($urandom);
            end
            if (idx < total && bus.nib_valid && bus.nib_ready) idx++;
        end
        bus.nib_valid  = 1'b0;
        bus.load_start = 1'b0;
        accepted = idx;
    endtask

    // Without the checksum stage the session loop stops on the last write cycle.
    task automatic settle();
`ifndef PROG_LOADER_CSUM_EN
        @(negedge clk);
`endif
    endtask

    task automatic test_reset();
        logic [25:0] v;
        reset = 1'b1;
        bus.load_start = 1'b0;
        bus.nib_valid  = 1'b0;
        bus.NIB        = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        v = {bus.nib_ready, bus.im_we, bus.IM_WADDR, bus.IM_WDATA, bus.set_pc, bus.busy, bus.done, bus.err};
        checks++;
        if (v !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", v, RST_VEC);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.NIB = 4'($urandom);
            checks++;
            if ({bus.set_pc, bus.nib_ready, bus.im_we, bus.done} !== 4'b1000) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: got %b expected 1000", i,
                         {bus.set_pc, bus.nib_ready, bus.im_we, bus.done});
            end
        end
    endtask

    task automatic test_basic();
        bit to;
        stream = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
`ifdef PROG_LOADER_CSUM_EN
        add_csum(1'b0);
`endif
        pulse_start();
        checks++;
        if ({bus.nib_ready, bus.busy, bus.set_pc, bus.done} !== 4'b1110) begin
            errors++;
            $display("FAIL start_load: got %b expected 1110", {bus.nib_ready, bus.busy, bus.set_pc, bus.done});
        end
        run_session(0, -1, to);
        checks++;
        if (to || got.size() != WORDS) begin
            errors++;
            $display("FAIL basic_session: timeout=%0d writes=%0d expected writes=%0d", to, got.size(), WORDS);
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                checks++;
                if (got[w].addr !== 4'(w) || got[w].data !== exp_word(w) || got[w].rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_write %0d: got addr=%h data=%h rdy=%b expected addr=%h data=%h rdy=0",
                             w, got[w].addr, got[w].data, got[w].rdy, 4'(w), exp_word(w));
                end
            end
            checks++;
            if (got[1].cyc - got[0].cyc != 5) begin
                errors++;
                $display("FAIL write_spacing: got %0d cycles expected 5", got[1].cyc - got[0].cyc);
            end
        end
        settle();
        checks++;
        if ({bus.set_pc, bus.done, bus.busy, bus.nib_ready, bus.err} !== 5'b01000) begin
            errors++;
            $display("FAIL basic_run: got %b expected 01000", {bus.set_pc, bus.done, bus.busy, bus.nib_ready, bus.err});
        end
        for (int i = 0; i < 4; i++) begin
            bus.nib_valid = 1'b1;
            bus.NIB       = 4'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.im_we, bus.nib_ready, bus.done, bus.set_pc} !== 4'b0010) begin
                errors++;
                $display("FAIL run_ignores_valid cycle %0d: got %b expected 0010", i,
                         {bus.im_we, bus.nib_ready, bus.done, bus.set_pc});
            end
        end
        bus.nib_valid = 1'b0;
    endtask

    task automatic test_toggle();
        bit to;
        pulse_start();
        run_session(1, -1, to);
        checks++;
        if (to || got.size() != WORDS) begin
            errors++;
            $display("FAIL toggle_session: timeout=%0d writes=%0d expected writes=%0d", to, got.size(), WORDS);
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                checks++;
                if (got[w].addr !== 4'(w) || got[w].data !== exp_word(w)) begin
                    errors++;
                    $display("FAIL toggle_write %0d: got addr=%h data=%h expected addr=%h data=%h",
                             w, got[w].addr, got[w].data, 4'(w), exp_word(w));
                end
            end
        end
        settle();
        checks++;
        if ({bus.set_pc, bus.done, bus.busy} !== 3'b010) begin
            errors++;
            $display("FAIL toggle_run: got %b expected 010", {bus.set_pc, bus.done, bus.busy});
        end
    endtask

    task automatic test_reset_mid();
        bit          to;
        logic [25:0] v;
        fill_random();
        pulse_start();
        run_session(0, 3, to);
        checks++;
        if (to || accepted != 3 || got.size() != 0) begin
            errors++;
            $display("FAIL partial_load: timeout=%0d accepted=%0d writes=%0d expected 3 accepted 0 writes",
                     to, accepted, got.size());
        end
        reset = 1'b1;
        @(negedge clk);
        v = {bus.nib_ready, bus.im_we, bus.IM_WADDR, bus.IM_WDATA, bus.set_pc, bus.busy, bus.done, bus.err};
        checks++;
        if (v !== RST_VEC) begin
            errors++;
            $display("FAIL mid_reset_values: got %h expected %h", v, RST_VEC);
        end
        reset = 1'b0;
        fill_random();
        pulse_start();
        run_session(2, -1, to);
        checks++;
        if (to || got.size() != WORDS) begin
            errors++;
            $display("FAIL reload_session: timeout=%0d writes=%0d expected writes=%0d", to, got.size(), WORDS);
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                checks++;
                if (got[w].addr !== 4'(w) || got[w].data !== exp_word(w)) begin
                    errors++;
                    $display("FAIL reload_write %0d: got addr=%h data=%h expected addr=%h data=%h",
                             w, got[w].addr, got[w].data, 4'(w), exp_word(w));
                end
            end
        end
        settle();
    endtask

    task automatic test_restart();
        bit to;
        stream.delete();
        for (int i = 0; i < 4; i++) stream.push_back(4'hF);
        for (int i = 4; i < 4*WORDS; i++) stream.push_back(4'($urandom));
`ifdef PROG_LOADER_CSUM_EN
        add_csum(1'b0);
`endif
        pulse_start();
        checks++;
        if ({bus.set_pc, bus.done, bus.nib_ready, bus.busy} !== 4'b1011) begin
            errors++;
            $display("FAIL restart_from_run: got %b expected 1011", {bus.set_pc, bus.done, bus.nib_ready, bus.busy});
        end
        run_session(0, -1, to);
        checks++;
        if (to || got.size() != WORDS || got[0].addr !== 4'h0 || got[0].data !== 16'hFFFF) begin
            errors++;
            $display("FAIL restart_write0: timeout=%0d writes=%0d got data=%h expected FFFF at 0",
                     to, got.size(), (got.size() > 0) ? got[0].data : 16'hxxxx);
        end
        settle();
        checks++;
        if ({bus.set_pc, bus.done} !== 2'b01) begin
            errors++;
            $display("FAIL restart_run: got %b expected 01", {bus.set_pc, bus.done});
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        for (int s = 0; s < 5; s++) begin
            fill_random();
            pulse_start();
            run_session(2, -1, to);
            checks++;
            if (to || got.size() != WORDS) begin
                errors++;
                $display("FAIL b2b_session %0d: timeout=%0d writes=%0d expected writes=%0d", s, to, got.size(), WORDS);
            end else begin
                for (int w = 0; w < WORDS; w++) begin
                    checks++;
                    if (got[w].addr !== 4'(w) || got[w].data !== exp_word(w)) begin
                        errors++;
                        $display("FAIL b2b_write %0d.%0d: got addr=%h data=%h expected addr=%h data=%h",
                                 s, w, got[w].addr, got[w].data, 4'(w), exp_word(w));
                    end
                end
            end
            settle();
            checks++;
            if ({bus.set_pc, bus.done, bus.busy, bus.err} !== 4'b0100) begin
                errors++;
                $display("FAIL b2b_run %0d: got %b expected 0100", s, {bus.set_pc, bus.done, bus.busy, bus.err});
            end
        end
    endtask

`ifdef PROG_LOADER_CSUM_EN
    task automatic test_csum();
        bit to;
        stream.delete();
        for (int i = 0; i < 4*WORDS; i++) stream.push_back(4'($urandom));
        add_csum(1'b1);
        pulse_start();
        run_session(2, -1, to);
        checks++;
        if (to || {bus.err, bus.set_pc, bus.done, bus.busy, bus.nib_ready} !== 5'b11000) begin
            errors++;
            $display("FAIL csum_bad: timeout=%0d got %b expected 11000", to,
                     {bus.err, bus.set_pc, bus.done, bus.busy, bus.nib_ready});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.err, bus.set_pc, bus.done} !== 3'b110) begin
            errors++;
            $display("FAIL csum_error_hold: got %b expected 110", {bus.err, bus.set_pc, bus.done});
        end
        fill_random();
        pulse_start();
        checks++;
        if ({bus.err, bus.nib_ready, bus.busy} !== 3'b011) begin
            errors++;
            $display("FAIL csum_error_exit: got %b expected 011", {bus.err, bus.nib_ready, bus.busy});
        end
        run_session(2, -1, to);
        checks++;
        if (to || {bus.err, bus.set_pc, bus.done} !== 3'b001) begin
            errors++;
            $display("FAIL csum_good: timeout=%0d got %b expected 001", to, {bus.err, bus.set_pc, bus.done});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_reset_mid();
        test_restart();
        test_back_to_back();
`ifdef PROG_LOADER_CSUM_EN
        test_csum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
